debug_frame_rx: RTL and testbench
=================================

# debug_frame_rx

Receive-side counterpart of the debugger frame transmitter. Pops bytes from the UART receive buffer and reassembles them, MSB byte first, into one wide frame register. Presents each complete frame with a one-cycle valid pulse. Discards a partial frame after a configurable inter-byte silence so the link resynchronises. Used on the host/loopback side, and by the self-check harness, to capture the debugger bus snapshot sent by the pipeline debugger.

## Interface
- FRAME_BYTES, 212: bytes per frame. The 1696-bit debugger bus is 212 bytes. Must be ≥ 2.
- TIMEOUT_CYCLES, 1000000: maximum idle clock cycles allowed between bytes inside a frame. Must be ≥ 4.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- r_data  in  8  UART receive buffer byte. Valid while rx_ready = 1.
- rx_ready  in  1  level: the receive buffer holds an unread byte. The UART clears it on the cycle after rd_uart.
- rd_uart  out  1  one-cycle pop strobe to the UART receive buffer.
- frame_data  out  FRAME_BYTES*8  last complete frame. Byte 0 received sits in the top 8 bits.
- frame_valid  out  1  one-cycle pulse: frame_data has just been updated.
- byte_count  out  clog2(FRAME_BYTES+1)  number of bytes of the current partial frame accepted so far.
- timeout_err  out  1  one-cycle pulse: a partial frame was discarded on timeout.

## Operation
- Datapath:
  - Shift register sh, FRAME_BYTES*8 bits wide.
  - Byte counter cnt, same width as byte_count.
  - Gap counter gap, clog2(TIMEOUT_CYCLES) bits.
- FSM states: COLLECT, ACK.
- COLLECT, rx_ready = 1:
  - rd_uart <= 1.
  - If cnt = FRAME_BYTES-1 (last byte):
    - frame_data <= {sh[FRAME_BYTES*8-9:0], r_data}.
    - frame_valid <= 1.
    - cnt <= 0.
  - Otherwise:
    - sh <= {sh[FRAME_BYTES*8-9:0], r_data}.
    - cnt <= cnt+1.
  - gap <= 0.
  - Next state ACK.
- COLLECT, rx_ready = 0:
  - While cnt ≠ 0, gap increments.
  - When gap = TIMEOUT_CYCLES-1: cnt <= 0, gap <= 0, timeout_err <= 1. sh is not cleared; the stale contents are shifted out by the next frame.
  - While cnt = 0, gap holds at 0. The idle time before the first byte of a frame never times out.
- ACK:
  - Lasts exactly one cycle and ignores rx_ready, covering the cycle in which the UART is still clearing it.
  - gap keeps counting if cnt ≠ 0.
  - Next state COLLECT.
- Simultaneous events: if rx_ready = 1 in COLLECT on the same cycle gap would reach TIMEOUT_CYCLES-1, the byte wins. The byte is accepted, gap resets, and there is no timeout_err.
- frame_data is only written on frame completion. It holds its value through timeouts and partial frames.
- byte_count = cnt.
- Width rule: the byte shifts into the LSBs and earlier bytes move up, so after FRAME_BYTES bytes the first byte lands in bits [FRAME_BYTES*8-1 : FRAME_BYTES*8-8]. This is the byte order the debugger transmitter sends.

## Timing
- Reset (reset = 0, asynchronous):
  - State COLLECT.
  - sh, cnt, gap = 0.
  - frame_data = 0.
  - rd_uart, frame_valid, timeout_err = 0.
  - A reset mid-frame discards the partial frame.
  - A reset does not generate timeout_err.
- All outputs are registered.
- rx_ready sampled high in COLLECT at cycle N gives rd_uart = 1 in cycle N+1.
- For the last byte, frame_valid = 1 in the same cycle N+1, with frame_data already updated.
- Maximum acceptance rate is one byte per 2 cycles. The minimum spacing between rd_uart pulses is 2 cycles.
- frame_valid and timeout_err are never both high in the same cycle.
- Timeout: after the last accepted byte's capture edge, timeout_err pulses TIMEOUT_CYCLES cycles later if no rx_ready arrives in between.

## Test plan
- Frame assembly (FRAME_BYTES=4): bytes 0x12, 0x34, 0x56, 0x78, each with rx_ready held until rd_uart.
  - Exactly four rd_uart pulses.
  - frame_valid pulses once, in the cycle of the fourth rd_uart.
  - frame_data = 0x12345678, byte_count returns to 0.
- Default width: 212 bytes with values 0x00..0xD3 at 20-cycle spacing.
  - frame_data[1695:1688] = 0x00 and frame_data[7:0] = 0xD3.
  - One frame_valid pulse.
- Back-to-back frames (FRAME_BYTES=4): rx_ready held continuously, 8 bytes 0x01..0x08.
  - rd_uart every 2nd cycle.
  - frame_valid twice; frame_data reads 0x01020304, then 0x05060708.
- Timeout (FRAME_BYTES=4, TIMEOUT_CYCLES=16): send 2 bytes, then idle.
  - timeout_err pulses 16 cycles after the 2nd capture edge; byte_count goes to 0.
  - Then send 0xA1, 0xA2, 0xA3, 0xA4: frame_data = 0xA1A2A3A4.
  - frame_data keeps its previous value until then.
- Boundary race (TIMEOUT_CYCLES=16): assert rx_ready exactly on the expiry cycle.
  - Byte accepted, byte_count increments, no timeout_err.
- Reset mid-frame (FRAME_BYTES=4): pull reset low after 3 bytes of a frame.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, a fresh 4-byte frame is assembled correctly.
  - No timeout_err at any point.

Source files
------------

// File: rtl/debug_frame_rx_if.sv
// Byte/frame bundle between the UART receive buffer, the frame receiver and
// whatever consumes the reassembled frame.
// master: the UART/host side, which supplies bytes and observes frames.
// slave:  the frame receiver itself.
interface debug_frame_rx_if #(
  parameter int FRAME_BYTES = 212
);
  localparam int CW = $clog2(FRAME_BYTES + 1);

  logic [7:0]               r_data;
  logic                     rx_ready;
  logic                     rd_uart;
  logic [FRAME_BYTES*8-1:0] frame_data;
  logic                     frame_valid;
  logic [CW-1:0]            byte_count;
  logic                     timeout_err;

  modport master (
    output r_data, rx_ready,
    input  rd_uart, frame_data, frame_valid, byte_count, timeout_err
  );

  modport slave (
    input  r_data, rx_ready,
    output rd_uart, frame_data, frame_valid, byte_count, timeout_err
  );
endinterface

// File: rtl/debug_frame_rx.sv
// Debugger frame receiver: pops bytes from the UART receive buffer and
// reassembles them MSB byte first into one wide frame. A partial frame is
// dropped after too long a silence between bytes so the link resynchronises.
module debug_frame_rx #(
  parameter int FRAME_BYTES    = 212,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            clock,
  input  logic            reset,
  debug_frame_rx_if.slave bus
);
  localparam int FW = FRAME_BYTES * 8;
  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam int GW = $clog2(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BYTES - 1);
  localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    ACK     = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // Only the bytes preceding the newest one are kept: the oldest byte of a
  // full shift register would be pushed out before it could ever be read, so
  // the register holds FRAME_BYTES-1 bytes and the incoming byte completes it.
  logic [FW-9:0]   sh_r;
  logic [FW-1:0]   shift_s;
  logic [FW-1:0]   frame_data_r;
  logic [CW-1:0]   cnt_r;
  logic [GW-1:0]   gap_r;
  logic            rd_uart_r;
  logic            frame_valid_r;
  logic            timeout_err_r;

  logic            take_s;
  logic            last_s;
  logic            expire_s;

  // A byte is only taken in COLLECT; ACK covers the cycle the UART needs to
  // drop rx_ready after the pop. A byte arriving on the expiry cycle wins.
  assign take_s   = (state_r == COLLECT) && bus.rx_ready;
  assign last_s   = (cnt_r == CNT_LAST);
  assign expire_s = (state_r == COLLECT) && !bus.rx_ready &&
                    (cnt_r != CNT_ZERO) && (gap_r == GAP_LAST);
  assign shift_s  = {sh_r, bus.r_data};

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: one ACK cycle after every accepted byte.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      COLLECT: begin
        if (take_s) begin
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      ACK:     state_nxt_s = COLLECT;
      default: state_nxt_s = COLLECT;
    endcase
  end

  // Datapath: byte shifting, frame capture, byte and silence counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_r          <= {(FW-8){1'b0}};
      frame_data_r  <= {FW{1'b0}};
      cnt_r         <= CNT_ZERO;
      gap_r         <= GAP_ZERO;
      rd_uart_r     <= 1'b0;
      frame_valid_r <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      rd_uart_r     <= take_s;
      frame_valid_r <= take_s && last_s;
      timeout_err_r <= expire_s;
      if (take_s) begin
        gap_r <= GAP_ZERO;
        if (last_s) begin
          // The old shift contents are left stale; the next frame's bytes
          // push them out before they could reach frame_data.
          frame_data_r <= shift_s;
          cnt_r        <= CNT_ZERO;
        end else begin
          sh_r  <= shift_s[FW-9:0];
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else if (expire_s) begin
        cnt_r <= CNT_ZERO;
        gap_r <= GAP_ZERO;
      end else if (cnt_r != CNT_ZERO) begin
        gap_r <= gap_r + GAP_ONE;
      end else begin
        // Idle before a frame's first byte never times out.
        gap_r <= GAP_ZERO;
      end
    end
  end

  assign bus.rd_uart     = rd_uart_r;
  assign bus.frame_data  = frame_data_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.byte_count  = cnt_r;
  assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_debug_frame_rx.sv
// Bench for debug_frame_rx: a 4-byte/16-cycle-timeout instance for the
// protocol corner cases and a default 212-byte instance for full width.
// Expected frames are queued when the last byte is driven and compared when
// frame_valid pulses.
module tb_debug_frame_rx;
  logic clock;
  logic rst4_n;
  logic rst2_n;

  debug_frame_rx_if #(.FRAME_BYTES(4))   u4 ();
  debug_frame_rx_if #(.FRAME_BYTES(212)) u2 ();

  debug_frame_rx #(.FRAME_BYTES(4), .TIMEOUT_CYCLES(16)) dut4 (
    .clock (clock),
    .reset (rst4_n),
    .bus   (u4)
  );

  debug_frame_rx dut212 (
    .clock (clock),
    .reset (rst2_n),
    .bus   (u2)
  );

  int checks = 0;
  int errors = 0;
  int rd4_cnt = 0;
  int fv4_cnt = 0;
  int to4_cnt = 0;
  int fv2_cnt = 0;
  logic prev_rd4 = 1'b0;
  logic [31:0]   q4[$];
  logic [1695:0] q2[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts pulses and pops the frame scoreboards.
  always @(posedge clock) begin
    logic [1695:0] e2;
    #1;
    if (u4.rd_uart === 1'b1) begin
      rd4_cnt++;
      check_value("rd4_spacing", prev_rd4, 1'b0);
    end
    prev_rd4 = u4.rd_uart;
    if (u4.timeout_err === 1'b1) to4_cnt++;
    if (u4.frame_valid === 1'b1 || u4.timeout_err === 1'b1)
      check_value("fv_to_excl", {u4.frame_valid, u4.timeout_err} == 2'b11, 1'b0);
    if (u4.frame_valid === 1'b1) begin
      fv4_cnt++;
      check_value("fv4_with_rd", u4.rd_uart, 1'b1);
      check_value("sb4_nonempty", q4.size() > 0, 1'b1);
      if (q4.size() > 0) check_value("frame4", u4.frame_data, q4.pop_front());
    end
    if (u2.frame_valid === 1'b1) begin
      fv2_cnt++;
      check_value("sb2_nonempty", q2.size() > 0, 1'b1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        for (int j = 0; j < 212; j++)
          check_value($sformatf("frame212_b%0d", j), u2.frame_data[1695-8*j -: 8], e2[1695-8*j -: 8]);
      end
    end
  end

  // Present one byte to the 4-byte instance and wait for its pop strobe.
  task automatic send4(input logic [7:0] b, input bit hold, output int waited);
    waited = 0;
    u4.r_data   = b;
    u4.rx_ready = 1'b1;
    do begin
      @(negedge clock);
      waited++;
    end while (u4.rd_uart !== 1'b1 && waited < 40);
    check_value("rd4_seen", u4.rd_uart, 1'b1);
    if (!hold) u4.rx_ready = 1'b0;
  endtask

  // Present one byte to the 212-byte instance at 20-cycle spacing.
  task automatic send2(input logic [7:0] b);
    int waited;
    waited = 0;
    u2.r_data   = b;
    u2.rx_ready = 1'b1;
    do begin
      @(negedge clock);
      waited++;
    end while (u2.rd_uart !== 1'b1 && waited < 40);
    if (u2.rd_uart !== 1'b1) check_value("rd2_seen", u2.rd_uart, 1'b1);
    u2.rx_ready = 1'b0;
    repeat (20 - waited) @(negedge clock);
  endtask

  initial begin
    logic [7:0]    pat[4];
    logic [1695:0] e212;
    int w, k, b_rd, b_fv, b_to;

    rst4_n = 1'b0;
    rst2_n = 1'b0;
    u4.r_data = 8'h00; u4.rx_ready = 1'b0;
    u2.r_data = 8'h00; u2.rx_ready = 1'b0;
    #2;
    check_value("rst_frame", u4.frame_data, 32'h0);
    check_value("rst_count", u4.byte_count, 3'd0);
    check_value("rst_rd",    u4.rd_uart, 1'b0);
    check_value("rst_fv",    u4.frame_valid, 1'b0);
    check_value("rst_to",    u4.timeout_err, 1'b0);
    check_value("rst2_top",  u2.frame_data[1695:1632], 64'h0);
    repeat (2) @(negedge clock);
    rst4_n = 1'b1;
    rst2_n = 1'b1;
    @(negedge clock);

    // Single frame assembly.
    b_rd = rd4_cnt; b_fv = fv4_cnt; b_to = to4_cnt;
    pat = '{8'h12, 8'h34, 8'h56, 8'h78};
    q4.push_back(32'h12345678);
    for (int i = 0; i < 4; i++) begin
      send4(pat[i], 1'b0, w);
      if (i < 3) check_value("asm_count", u4.byte_count, 3'(i + 1));
    end
    check_value("asm_fv_now", u4.frame_valid, 1'b1);
    check_value("asm_count0", u4.byte_count, 3'd0);
    check_value("asm_frame", u4.frame_data, 32'h12345678);
    @(negedge clock);
    check_value("asm_rd_pulses", rd4_cnt - b_rd, 4);
    check_value("asm_fv_pulses", fv4_cnt - b_fv, 1);

    // Back-to-back frames with rx_ready held.
    b_fv = fv4_cnt;
    q4.push_back(32'h01020304);
    q4.push_back(32'h05060708);
    for (int i = 0; i < 8; i++) begin
      send4(8'(i + 1), 1'b1, w);
      if (i > 0) check_value("b2b_spacing", w, 2);
    end
    u4.rx_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_value("b2b_fv_pulses", fv4_cnt - b_fv, 2);
    check_value("b2b_frame", u4.frame_data, 32'h05060708);

    // Timeout after a 2-byte partial frame.
    send4(8'hAA, 1'b0, w);
    send4(8'hBB, 1'b0, w);
    check_value("to_count2", u4.byte_count, 3'd2);
    k = 0;
    while (u4.timeout_err !== 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
    end
    check_value("to_delay", k, 16);
    check_value("to_count0", u4.byte_count, 3'd0);
    check_value("to_hold_frame", u4.frame_data, 32'h05060708);
    @(negedge clock);
    check_value("to_pulses", to4_cnt - b_to, 1);
    q4.push_back(32'hA1A2A3A4);
    send4(8'hA1, 1'b0, w);
    send4(8'hA2, 1'b0, w);
    send4(8'hA3, 1'b0, w);
    check_value("to_hold_partial", u4.frame_data, 32'h05060708);
    send4(8'hA4, 1'b0, w);
    check_value("to_new_frame", u4.frame_data, 32'hA1A2A3A4);

    // Byte arriving exactly on the expiry edge.
    b_to = to4_cnt;
    send4(8'hB1, 1'b0, w);
    repeat (15) @(negedge clock);
    check_value("race_pre_to", u4.timeout_err, 1'b0);
    u4.r_data   = 8'hB2;
    u4.rx_ready = 1'b1;
    @(negedge clock);
    u4.rx_ready = 1'b0;
    check_value("race_rd", u4.rd_uart, 1'b1);
    check_value("race_count", u4.byte_count, 3'd2);
    check_value("race_no_to", u4.timeout_err, 1'b0);
    q4.push_back(32'hB1B2B3B4);
    send4(8'hB3, 1'b0, w);
    send4(8'hB4, 1'b0, w);
    @(negedge clock);
    check_value("race_to_pulses", to4_cnt - b_to, 0);

    // Asynchronous reset in the middle of a frame.
    b_to = to4_cnt;
    send4(8'hC1, 1'b0, w);
    send4(8'hC2, 1'b0, w);
    send4(8'hC3, 1'b1, w);
    #1 rst4_n = 1'b0;
    #1;
    check_value("mid_rst_frame", u4.frame_data, 32'h0);
    check_value("mid_rst_count", u4.byte_count, 3'd0);
    check_value("mid_rst_rd",    u4.rd_uart, 1'b0);
    check_value("mid_rst_fv",    u4.frame_valid, 1'b0);
    check_value("mid_rst_to",    u4.timeout_err, 1'b0);
    u4.rx_ready = 1'b0;
    repeat (2) @(negedge clock);
    rst4_n = 1'b1;
    repeat (30) @(negedge clock);
    q4.push_back(32'hD1D2D3D4);
    send4(8'hD1, 1'b0, w);
    send4(8'hD2, 1'b0, w);
    send4(8'hD3, 1'b0, w);
    send4(8'hD4, 1'b0, w);
    check_value("post_rst_frame", u4.frame_data, 32'hD1D2D3D4);
    @(negedge clock);
    check_value("rst_no_to", to4_cnt - b_to, 0);

    // Full-width frame on the default instance.
    for (int i = 0; i < 212; i++) e212[1695-8*i -: 8] = 8'(i);
    q2.push_back(e212);
    for (int i = 0; i < 212; i++) send2(8'(i));
    repeat (2) @(negedge clock);
    check_value("w212_fv_pulses", fv2_cnt, 1);
    check_value("w212_top", u2.frame_data[1695:1688], 8'h00);
    check_value("w212_bot", u2.frame_data[7:0], 8'hD3);
    check_value("w212_count0", u2.byte_count, 8'd0);

    check_value("sb4_drained", q4.size(), 0);
    check_value("sb2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
